// File: rtl/calc_exec_unit_if.sv
// Operation/result handshake bundle between the control decoder and the
// calculator execute stage.
interface calc_exec_unit_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic             sign_control;
   logic             store_prev_control;
   logic             mem_control;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             overflow;

   modport master (
      output in_valid, operand_a, operand_b, sign_control,
             store_prev_control, mem_control, out_ready,
      input  in_ready, out_valid, result, overflow
   );

   modport slave (
      input  in_valid, operand_a, operand_b, sign_control,
             store_prev_control, mem_control, out_ready,
      output in_ready, out_valid, result, overflow
   );
endinterface

// File: rtl/calc_exec_unit.sv
// Calculator execute stage: signed add/sub, previous-result register and circular result history.
// Optional macro CALC_SATURATE_EN clamps overflowing results to the signed range limits.
module calc_exec_unit #(
   parameter int WIDTH      = 32,
   parameter int HIST_DEPTH = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   calc_exec_unit_if.slave                   bus,
   output logic [WIDTH-1:0]                  prev_value,
   output logic [$clog2(HIST_DEPTH+1)-1:0]   hist_count,
   input  logic [$clog2(HIST_DEPTH)-1:0]     hist_rd_idx,
   output logic [WIDTH-1:0]                  hist_rd_data
);
   localparam int PW = $clog2(HIST_DEPTH);
   localparam int CW = $clog2(HIST_DEPTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_next_s;
   logic             accept_s;
   logic             exec_s;
   logic             in_ready_r;
   logic             out_valid_r;

   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic             sign_r;
   logic             store_r;
   logic             mem_r;

   logic [WIDTH-1:0] x_s;
   logic [WIDTH-1:0] sum_s;
   logic [WIDTH-1:0] res_s;
   logic             ovf_s;
   logic [WIDTH-1:0] result_r;
   logic             overflow_r;
   logic [WIDTH-1:0] prev_r;

   logic [WIDTH-1:0] hist_mem_r [HIST_DEPTH];
   logic [PW-1:0]    wr_ptr_r;
   logic [CW-1:0]    hist_count_r;
   logic [PW-1:0]    rd_ptr_s;
   logic [WIDTH-1:0] hist_rd_data_s;

   // Subtraction overflows when operand signs differ; addition when they match.
   function automatic logic calc_overflow(input logic x_msb, input logic b_msb,
                                          input logic r_msb, input logic sub);
      if (sub) begin
         calc_overflow = (x_msb != b_msb) && (r_msb != x_msb);
      end else begin
         calc_overflow = (x_msb == b_msb) && (r_msb != x_msb);
      end
   endfunction

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state and datapath strobes
   always_comb begin
      state_next_s = state_r;
      accept_s     = 1'b0;
      exec_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.in_valid) begin
               accept_s     = 1'b1;
               state_next_s = ST_EXEC;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_EXEC: begin
            exec_s       = 1'b1;
            state_next_s = ST_HOLD;
         end
         ST_HOLD: begin
            if (bus.out_ready) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_HOLD;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Handshake flags registered from the upcoming state
   always_ff @(posedge clk) begin
      if (reset) begin
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         in_ready_r  <= (state_next_s == ST_IDLE);
         out_valid_r <= (state_next_s == ST_HOLD);
      end
   end

   // Arithmetic on the latched operation
   always_comb begin
      x_s   = store_r ? prev_r : a_r;
      sum_s = sign_r ? (x_s - b_r) : (x_s + b_r);
      ovf_s = calc_overflow(x_s[WIDTH-1], b_r[WIDTH-1], sum_s[WIDTH-1], sign_r);
`ifdef CALC_SATURATE_EN
      // Overflow direction follows the sign of x in both add and subtract.
      if (ovf_s) begin
         if (x_s[WIDTH-1]) begin
            res_s = {1'b1, {(WIDTH-1){1'b0}}};
         end else begin
            res_s = {1'b0, {(WIDTH-1){1'b1}}};
         end
      end else begin
         res_s = sum_s;
      end
`else
      res_s = sum_s;
`endif
   end

   // Operand latch, result/prev registers and history push
   always_ff @(posedge clk) begin
      if (reset) begin
         a_r          <= {WIDTH{1'b0}};
         b_r          <= {WIDTH{1'b0}};
         sign_r       <= 1'b0;
         store_r      <= 1'b0;
         mem_r        <= 1'b0;
         result_r     <= {WIDTH{1'b0}};
         overflow_r   <= 1'b0;
         prev_r       <= {WIDTH{1'b0}};
         wr_ptr_r     <= {PW{1'b0}};
         hist_count_r <= {CW{1'b0}};
         for (int i = 0; i < HIST_DEPTH; i++) begin
            hist_mem_r[i] <= {WIDTH{1'b0}};
         end
      end else begin
         if (accept_s) begin
            a_r     <= bus.operand_a;
            b_r     <= bus.operand_b;
            sign_r  <= bus.sign_control;
            store_r <= bus.store_prev_control;
            mem_r   <= bus.mem_control;
         end
         if (exec_s) begin
            result_r   <= res_s;
            overflow_r <= ovf_s;
            prev_r     <= res_s;
            if (mem_r) begin
               hist_mem_r[wr_ptr_r] <= res_s;
               wr_ptr_r             <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
               if (hist_count_r != CW'(HIST_DEPTH)) begin
                  hist_count_r <= hist_count_r + {{(CW-1){1'b0}}, 1'b1};
               end
            end
         end
      end
   end

   // Newest-first history read; indices past the fill level read as zero
   always_comb begin
      rd_ptr_s = wr_ptr_r - {{(PW-1){1'b0}}, 1'b1} - hist_rd_idx;
      if ({1'b0, hist_rd_idx} >= hist_count_r) begin
         hist_rd_data_s = {WIDTH{1'b0}};
      end else begin
         hist_rd_data_s = hist_mem_r[rd_ptr_s];
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.result    = result_r;
   assign bus.overflow  = overflow_r;
   assign prev_value    = prev_r;
   assign hist_count    = hist_count_r;
   assign hist_rd_data  = hist_rd_data_s;

endmodule

// File: tb/tb_calc_exec_unit.sv
// Directed testbench for calc_exec_unit; expectations follow CALC_SATURATE_EN when defined.
module tb_calc_exec_unit;
   logic        clk;
   logic        reset;
   logic [31:0] prev_value;
   logic [2:0]  hist_count;
   logic [1:0]  hist_rd_idx;
   logic [31:0] hist_rd_data;
   int          tests_run;
   int          tests_failed;

   calc_exec_unit_if #(.WIDTH(32)) bus ();

   calc_exec_unit #(.WIDTH(32), .HIST_DEPTH(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus),
      .prev_value   (prev_value),
      .hist_count   (hist_count),
      .hist_rd_idx  (hist_rd_idx),
      .hist_rd_data (hist_rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Issue one op with out_ready high; operands are scrambled after the accept edge.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic sp, input logic mem,
                         output logic [31:0] res, output logic ovf, output int lat);
      bus.operand_a          = a;
      bus.operand_b          = b;
      bus.sign_control       = sgn;
      bus.store_prev_control = sp;
      bus.mem_control        = mem;
      bus.out_ready          = 1'b1;
      bus.in_valid           = 1'b1;
      tick();
      bus.in_valid  = 1'b0;
      bus.operand_a = 32'hDEAD_BEEF;
      bus.operand_b = 32'h1234_5678;
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 10) begin
         tick();
         lat++;
      end
      res = bus.result;
      ovf = bus.overflow;
      tick();
   endtask

   task automatic test_reset();
      tests_run++;
      if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
      tests_run++;
      if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
      tests_run++;
      if (bus.result !== 32'h0) begin tests_failed++; $display("FAIL reset_result: got %h expected 0", bus.result); end
      tests_run++;
      if (prev_value !== 32'h0) begin tests_failed++; $display("FAIL reset_prev: got %h expected 0", prev_value); end
      tests_run++;
      if (hist_count !== 3'd0) begin tests_failed++; $display("FAIL reset_hist_count: got %0d expected 0", hist_count); end
   endtask

   task automatic test_basic();
      logic [31:0] r; logic o; int lat;
      run_op(32'd5, 32'd3, 1'b0, 1'b0, 1'b0, r, o, lat);
      tests_run++;
      if (lat !== 2) begin tests_failed++; $display("FAIL basic_latency: got %0d expected 2", lat); end
      tests_run++;
      if (r !== 32'd8) begin tests_failed++; $display("FAIL basic_result: got %h expected 8", r); end
      tests_run++;
      if (o !== 1'b0) begin tests_failed++; $display("FAIL basic_overflow: got %b expected 0", o); end
      tests_run++;
      if (prev_value !== 32'd8) begin tests_failed++; $display("FAIL basic_prev: got %h expected 8", prev_value); end
      tests_run++;
      if (hist_count !== 3'd0) begin tests_failed++; $display("FAIL basic_hist_count: got %0d expected 0", hist_count); end
      tests_run++;
      if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL basic_back_idle: got %b expected 1", bus.in_ready); end
   endtask

   task automatic test_chain();
      logic [31:0] r; logic o; int lat;
      run_op(32'd10, 32'd4, 1'b1, 1'b0, 1'b0, r, o, lat);
      tests_run++;
      if (r !== 32'd6) begin tests_failed++; $display("FAIL chain_sub: got %h expected 6", r); end
      run_op(32'd999, 32'd6, 1'b0, 1'b1, 1'b1, r, o, lat);
      tests_run++;
      if (r !== 32'd12) begin tests_failed++; $display("FAIL chain_store_prev: got %h expected 12", r); end
      tests_run++;
      if (hist_count !== 3'd1) begin tests_failed++; $display("FAIL chain_hist_count: got %0d expected 1", hist_count); end
      hist_rd_idx = 2'd0;
      #1;
      tests_run++;
      if (hist_rd_data !== 32'd12) begin tests_failed++; $display("FAIL chain_hist0: got %h expected 12", hist_rd_data); end
      hist_rd_idx = 2'd1;
      #1;
      tests_run++;
      if (hist_rd_data !== 32'd0) begin tests_failed++; $display("FAIL chain_hist1_empty: got %h expected 0", hist_rd_data); end
   endtask

   task automatic test_store_prev_after_reset();
      logic [31:0] r; logic o; int lat;
      do_reset();
      run_op(32'd55, 32'd4, 1'b0, 1'b1, 1'b0, r, o, lat);
      tests_run++;
      if (r !== 32'd4) begin tests_failed++; $display("FAIL prev_after_reset: got %h expected 4", r); end
   endtask

   task automatic test_overflow();
      logic [31:0] r; logic o; int lat;
      logic [31:0] exp_pos; logic [31:0] exp_neg;
`ifdef CALC_SATURATE_EN
      exp_pos = 32'h7FFF_FFFF;
      exp_neg = 32'h8000_0000;
`else
      exp_pos = 32'h8000_0000;
      exp_neg = 32'h7FFF_FFFF;
`endif
      run_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1, r, o, lat);
      tests_run++;
      if (r !== exp_pos) begin tests_failed++; $display("FAIL ovf_pos_result: got %h expected %h", r, exp_pos); end
      tests_run++;
      if (o !== 1'b1) begin tests_failed++; $display("FAIL ovf_pos_flag: got %b expected 1", o); end
      tests_run++;
      if (prev_value !== exp_pos) begin tests_failed++; $display("FAIL ovf_pos_prev: got %h expected %h", prev_value, exp_pos); end
      hist_rd_idx = 2'd0;
      #1;
      tests_run++;
      if (hist_rd_data !== exp_pos) begin tests_failed++; $display("FAIL ovf_pos_hist: got %h expected %h", hist_rd_data, exp_pos); end
      run_op(32'h8000_0000, 32'd1, 1'b1, 1'b0, 1'b0, r, o, lat);
      tests_run++;
      if (r !== exp_neg) begin tests_failed++; $display("FAIL ovf_neg_result: got %h expected %h", r, exp_neg); end
      tests_run++;
      if (o !== 1'b1) begin tests_failed++; $display("FAIL ovf_neg_flag: got %b expected 1", o); end
      run_op(32'd5, 32'hFFFF_FFFD, 1'b1, 1'b0, 1'b0, r, o, lat);
      tests_run++;
      if (r !== 32'd8 || o !== 1'b0) begin tests_failed++; $display("FAIL sub_mixed_sign: got %h/%b expected 8/0", r, o); end
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, r, o, lat);
      tests_run++;
      if (r !== 32'hFFFF_FFFE || o !== 1'b0) begin tests_failed++; $display("FAIL add_neg_no_ovf: got %h/%b expected fffffffe/0", r, o); end
   endtask

   task automatic test_hist_wrap();
      logic [31:0] r; logic o; int lat;
      logic [31:0] exp_hist [4];
      exp_hist[0] = 32'd5; exp_hist[1] = 32'd4; exp_hist[2] = 32'd3; exp_hist[3] = 32'd2;
      do_reset();
      for (int k = 1; k <= 5; k++) begin
         run_op(32'(k), 32'd0, 1'b0, 1'b0, 1'b1, r, o, lat);
      end
      tests_run++;
      if (hist_count !== 3'd4) begin tests_failed++; $display("FAIL wrap_hist_count: got %0d expected 4", hist_count); end
      for (int k = 0; k < 4; k++) begin
         hist_rd_idx = 2'(k);
         #1;
         tests_run++;
         if (hist_rd_data !== exp_hist[k]) begin
            tests_failed++;
            $display("FAIL wrap_hist_idx%0d: got %h expected %h", k, hist_rd_data, exp_hist[k]);
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      bus.out_ready          = 1'b0;
      bus.operand_a          = 32'd7;
      bus.operand_b          = 32'd2;
      bus.sign_control       = 1'b0;
      bus.store_prev_control = 1'b0;
      bus.mem_control        = 1'b0;
      bus.in_valid           = 1'b1;
      tick();
      bus.operand_a = 32'd100;
      bus.operand_b = 32'd1;
      tick();
      for (int c = 0; c < 4; c++) begin
         tick();
         tests_run++;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== 32'd9) begin
            tests_failed++;
            $display("FAIL bp_hold_cycle%0d: got valid=%b ready=%b result=%h expected 1/0/9",
                     c, bus.out_valid, bus.in_ready, bus.result);
         end
      end
      bus.out_ready = 1'b1;
      tick();
      tests_run++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL bp_release_idle: got valid=%b ready=%b expected 0/1", bus.out_valid, bus.in_ready);
      end
      tick();
      tests_run++;
      if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_held_accept: got ready=%b expected 0", bus.in_ready); end
      bus.in_valid = 1'b0;
      tick();
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.result !== 32'd101) begin
         tests_failed++;
         $display("FAIL bp_held_result: got valid=%b result=%h expected 1/101", bus.out_valid, bus.result);
      end
      tick();
   endtask

   task automatic test_reset_midop();
      logic [31:0] r; logic o; int lat;
      run_op(32'd3, 32'd4, 1'b0, 1'b0, 1'b1, r, o, lat);
      tests_run++;
      if (hist_count !== 3'd1 || prev_value !== 32'd7) begin
         tests_failed++;
         $display("FAIL midop_setup: got count=%0d prev=%h expected 1/7", hist_count, prev_value);
      end
      bus.operand_a   = 32'd1;
      bus.operand_b   = 32'd1;
      bus.mem_control = 1'b1;
      bus.in_valid    = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      reset        = 1'b1;
      tick();
      reset = 1'b0;
      tests_run++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL midop_handshake: got valid=%b ready=%b expected 0/1", bus.out_valid, bus.in_ready);
      end
      tests_run++;
      if (prev_value !== 32'd0 || hist_count !== 3'd0 || bus.result !== 32'd0) begin
         tests_failed++;
         $display("FAIL midop_cleared: got prev=%h count=%0d result=%h expected 0/0/0",
                  prev_value, hist_count, bus.result);
      end
      tick();
      tests_run++;
      if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL midop_no_result: got valid=%b expected 0", bus.out_valid); end
   endtask

   initial begin
      tests_run              = 0;
      tests_failed           = 0;
      reset                  = 1'b1;
      bus.in_valid           = 1'b0;
      bus.operand_a          = 32'h0;
      bus.operand_b          = 32'h0;
      bus.sign_control       = 1'b0;
      bus.store_prev_control = 1'b0;
      bus.mem_control        = 1'b0;
      bus.out_ready          = 1'b1;
      hist_rd_idx            = 2'd0;
      do_reset();
      test_reset();
      test_basic();
      test_chain();
      test_store_prev_after_reset();
      test_overflow();
      test_hist_wrap();
      test_backpressure();
      test_reset_midop();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
